// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU: fetch FSM states, reset defaults
// and datapath/counter widths.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [INST_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register, variable-latency
// imem handshake, stall/flush handling and saturating debug counters.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCWrite_i,
  input  logic        IFIDWrite_i,
  input  logic        Flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] IF_ID_pc_o,
  output logic [31:0] IF_ID_inst_o,
  output logic        IF_ID_valid_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  fetch_state_t      state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] redirect_q, redirect_d;
  logic [INST_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              active;

  assign active = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH, DRAIN: begin
        if (Flush_i) begin
          // The outstanding address must not move, so a flush without ack
          // parks the target until the old request drains.
          ifid_pc_d    = pc_q;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          if (imem_ack_i) begin
            pc_d    = branch_target_i;
            state_d = FETCH;
          end else begin
            redirect_d = branch_target_i;
            state_d    = DRAIN;
          end
        end else if (state_q == FETCH) begin
          if (imem_ack_i && PCWrite_i && IFIDWrite_i) begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = imem_data_i;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else if (IFIDWrite_i && !(imem_ack_i && PCWrite_i)) begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
          end
        end else begin
          if (IFIDWrite_i) begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
          end
          if (imem_ack_i) begin
            pc_d    = redirect_q;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redirect_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (active && !PCWrite_i && !Flush_i),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (active && Flush_i),
    .cnt_o  (flush_cnt_o)
  );

  assign imem_req_o    = active;
  assign imem_addr_o   = pc_q;
  assign IF_ID_pc_o    = ifid_pc_q;
  assign IF_ID_inst_o  = ifid_inst_q;
  assign IF_ID_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit using immediate assertions.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        PCWrite_i;
  logic        IFIDWrite_i;
  logic        Flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] IF_ID_pc_o;
  logic [31:0] IF_ID_inst_o;
  logic        IF_ID_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  // Memory model: instruction word encodes its own address.
  assign imem_data_i = 32'hDEAD_0000 | imem_addr_o;

  fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .PCWrite_i       (PCWrite_i),
    .IFIDWrite_i     (IFIDWrite_i),
    .Flush_i         (Flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .IF_ID_pc_o      (IF_ID_pc_o),
    .IF_ID_inst_o    (IF_ID_inst_o),
    .IF_ID_valid_o   (IF_ID_valid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; PCWrite_i = 1'b1; IFIDWrite_i = 1'b1;
    Flush_i = 1'b0; branch_target_i = '0; imem_ack_i = 1'b0;
    #1;
    check("rst_req",   {31'b0, imem_req_o}, 32'd0);
    check("rst_addr",  imem_addr_o, 32'h0);
    check("rst_pc",    IF_ID_pc_o, 32'h0);
    check("rst_inst",  IF_ID_inst_o, 32'h0);
    check("rst_valid", {31'b0, IF_ID_valid_o}, 32'd0);
    check("rst_stall", {16'b0, stall_cnt_o}, 32'd0);
    check("rst_flush", {16'b0, flush_cnt_o}, 32'd0);
    step();
    rst_i = 1'b1;

    // Zero-wait streaming
    start_i = 1'b1; imem_ack_i = 1'b1;
    step();
    start_i = 1'b0;
    check("start_req",  {31'b0, imem_req_o}, 32'd1);
    check("stream_a0",  imem_addr_o, 32'h0);
    step();
    check("stream_a4",  imem_addr_o, 32'h4);
    check("stream_p0",  IF_ID_pc_o, 32'h0);
    check("stream_v0",  {31'b0, IF_ID_valid_o}, 32'd1);
    check("stream_i0",  IF_ID_inst_o, 32'hDEAD_0000);
    step();
    check("stream_a8",  imem_addr_o, 32'h8);
    check("stream_p4",  IF_ID_pc_o, 32'h4);

    // Load-use stall at pc_q=8
    PCWrite_i = 1'b0; IFIDWrite_i = 1'b0;
    step();
    PCWrite_i = 1'b1; IFIDWrite_i = 1'b1;
    check("stall_addr", imem_addr_o, 32'h8);
    check("stall_pc",   IF_ID_pc_o, 32'h4);
    check("stall_cnt",  {16'b0, stall_cnt_o}, 32'd1);
    step();
    check("resume_a12", imem_addr_o, 32'hC);
    check("resume_p8",  IF_ID_pc_o, 32'h8);
    step();
    check("stream_a16", imem_addr_o, 32'h10);
    check("stream_p12", IF_ID_pc_o, 32'hC);
    check("stream_v12", {31'b0, IF_ID_valid_o}, 32'd1);

    // Flush with ack in the same cycle
    Flush_i = 1'b1; branch_target_i = 32'h40;
    step();
    Flush_i = 1'b0;
    check("fl_valid",  {31'b0, IF_ID_valid_o}, 32'd0);
    check("fl_inst",   IF_ID_inst_o, 32'h0);
    check("fl_addr",   imem_addr_o, 32'h40);
    check("fl_cnt",    {16'b0, flush_cnt_o}, 32'd1);
    check("fl_stall",  {16'b0, stall_cnt_o}, 32'd1);
    step();
    check("fl_pc40",   IF_ID_pc_o, 32'h40);
    check("fl_i40",    IF_ID_inst_o, 32'hDEAD_0040);
    check("fl_a44",    imem_addr_o, 32'h44);

    // Redirect to 0x10, then wait states with flushes in flight
    Flush_i = 1'b1; branch_target_i = 32'h10;
    step();
    Flush_i = 1'b0; imem_ack_i = 1'b0;
    check("w_addr0", imem_addr_o, 32'h10);
    step();
    check("w_addr1",  imem_addr_o, 32'h10);
    check("w_req1",   {31'b0, imem_req_o}, 32'd1);
    check("w_bubble", {31'b0, IF_ID_valid_o}, 32'd0);
    Flush_i = 1'b1; branch_target_i = 32'h60;
    step();
    check("w_addr2", imem_addr_o, 32'h10);
    branch_target_i = 32'h80;
    step();
    check("w_addr3", imem_addr_o, 32'h10);
    check("w_flcnt", {16'b0, flush_cnt_o}, 32'd4);
    Flush_i = 1'b0; imem_ack_i = 1'b1;
    step();
    check("dr_addr",  imem_addr_o, 32'h80);
    check("dr_valid", {31'b0, IF_ID_valid_o}, 32'd0);
    check("dr_inst",  IF_ID_inst_o, 32'h0);
    step();
    check("dr_pc80",  IF_ID_pc_o, 32'h80);
    check("dr_i80",   IF_ID_inst_o, 32'hDEAD_0080);
    check("dr_v80",   {31'b0, IF_ID_valid_o}, 32'd1);
    check("dr_a84",   imem_addr_o, 32'h84);
    check("dr_stall", {16'b0, stall_cnt_o}, 32'd1);

    // Stall counter saturation
    PCWrite_i = 1'b0; IFIDWrite_i = 1'b0;
    repeat (65533) step();
    check("sat_fffe", {16'b0, stall_cnt_o}, 32'h0000_FFFE);
    repeat (5000) step();
    check("sat_ffff", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
    step();
    check("sat_hold", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
    PCWrite_i = 1'b1; IFIDWrite_i = 1'b1;

    // Reset during an outstanding request
    imem_ack_i = 1'b0;
    step();
    check("pre_rst_req", {31'b0, imem_req_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("arst_req",   {31'b0, imem_req_o}, 32'd0);
    check("arst_addr",  imem_addr_o, 32'h0);
    check("arst_pc",    IF_ID_pc_o, 32'h0);
    check("arst_valid", {31'b0, IF_ID_valid_o}, 32'd0);
    check("arst_stall", {16'b0, stall_cnt_o}, 32'd0);
    check("arst_flush", {16'b0, flush_cnt_o}, 32'd0);
    step();
    rst_i = 1'b1; imem_ack_i = 1'b1;
    step();
    step();
    check("late_req",   {31'b0, imem_req_o}, 32'd0);
    check("late_addr",  imem_addr_o, 32'h0);
    check("late_valid", {31'b0, IF_ID_valid_o}, 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("restart_req",  {31'b0, imem_req_o}, 32'd1);
    check("restart_addr", imem_addr_o, 32'h0);
    step();
    check("restart_pc", IF_ID_pc_o, 32'h0);
    check("restart_v",  {31'b0, IF_ID_valid_o}, 32'd1);
    check("restart_a4", imem_addr_o, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register for the five-stage CPU. It drives the PC and a variable-latency instruction-memory request/acknowledge handshake. It also obeys the stall and flush controls that hazard detection and branch resolution produce: hold, bubble or redirect. It sits between instruction memory and the ID stage and keeps saturating stall and flush counters for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  leave IDLE and begin fetching; sampled only in IDLE
- PCWrite_i  input  1  1 = PC may advance; 0 = hazard stall, refetch same address
- IFIDWrite_i  input  1  1 = IF/ID register may load; 0 = hold IF/ID
- Flush_i  input  1  branch taken; squash IF/ID and redirect
- branch_target_i  input  32  redirect address, valid with Flush_i
- imem_req_o  output  1  instruction request
- imem_addr_o  output  32  request address, stable while imem_req_o=1 and not acknowledged
- imem_ack_i  input  1  imem_data_i valid this cycle; ends the request
- imem_data_i  input  32  fetched instruction
- IF_ID_pc_o  output  32  PC of the instruction in IF/ID
- IF_ID_inst_o  output  32  instruction in IF/ID
- IF_ID_valid_o  output  1  0 = bubble
- stall_cnt_o  output  16  saturating count of stall cycles
- flush_cnt_o  output  16  saturating count of flush cycles

## Operation
- States: IDLE, FETCH, DRAIN.
- Registers: pc_q (outstanding request address), redirect_q, IF/ID {pc, inst, valid}, two counters.
- imem_req_o = (state != IDLE). imem_addr_o = pc_q.
- IDLE: start_i=1 moves to FETCH. Flush_i, PCWrite_i, IFIDWrite_i and imem_ack_i are ignored.
- FETCH, ack, no flush:
  - IFIDWrite_i=1 and PCWrite_i=1: IF/ID <= {pc_q, imem_data_i, 1} and pc_q <= pc_q+4 (wraps mod 2^32).
  - PCWrite_i=0: fetched word discarded; pc_q holds.
  - IFIDWrite_i=0: IF/ID holds.
- FETCH, no ack, no flush: IF/ID <= {pc_q, NOP_INST, 0} if IFIDWrite_i=1, else hold. pc_q holds.
- Flush_i=1 in FETCH or DRAIN has priority over PCWrite_i and IFIDWrite_i:
  - IF/ID <= bubble unconditionally.
  - If ack this cycle: pc_q <= branch_target_i; go to or stay in FETCH.
  - Else: redirect_q <= branch_target_i; go to or stay in DRAIN. The latest target wins.
- DRAIN, no flush:
  - Outstanding request completes at the old address.
  - On ack: data discarded, pc_q <= redirect_q, go to FETCH.
  - IF/ID loads a bubble whenever IFIDWrite_i=1.
- stall_cnt_o increments each non-IDLE cycle with PCWrite_i=0 and Flush_i=0.
- flush_cnt_o increments each non-IDLE cycle with Flush_i=1.
- Both counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, pc_q=RESET_PC, redirect_q=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - IF_ID_pc_o=0, IF_ID_inst_o=NOP_INST, IF_ID_valid_o=0.
  - Both counters 0.
- Reset mid-request drops imem_req_o at once. A late ack arrives in IDLE and is ignored.
- start_i sampled at edge N: imem_req_o=1 from cycle N+1.
- Zero-wait memory (ack in the request's own cycle):
  - Instruction visible on IF_ID_*_o at the next edge.
  - One instruction per cycle sustained.
- Handshake:
  - A request ends only on ack. The address never changes before ack, including during flush.
  - A new request begins the cycle after ack.
- Redirect latency, no outstanding wait: target requested the cycle after Flush_i.
- Redirect latency, outstanding wait: the old request drains first.
- All outputs are registered or decoded from state/pc_q only. No combinational path from inputs to outputs.

## Structure
- Shared package cpu_pkg:
  - fetch_state_t enum (IDLE, FETCH, DRAIN).
  - NOP_INST and RESET_PC defaults.
  - INST_W=32, CNT_W=16.
- One sub-module, sat_counter (CNT_W-bit, enable, saturate at all-ones, async active-low reset). It is instantiated twice.

## Test plan
- Reset then start_i with zero-wait memory:
  - imem_addr_o steps 0, 4, 8, 12 on consecutive cycles.
  - IF_ID_pc_o follows one cycle later with IF_ID_valid_o=1.
- Load-use stall:
  - Stimulus: PCWrite_i=IFIDWrite_i=0 for 1 cycle at pc_q=8.
  - IF/ID holds pc 4, imem_addr_o stays 8, then resumes 8→12.
  - stall_cnt_o=1.
- Flush with ack in the same cycle, branch_target_i=0x40:
  - IF/ID bubble (valid 0, inst NOP_INST) next cycle.
  - imem_addr_o=0x40 next cycle.
  - flush_cnt_o=1.
- Flush during a 3-cycle wait at address 0x10:
  - imem_addr_o stays 0x10 until ack.
  - Data discarded, then imem_addr_o=target.
  - Second flush in DRAIN to 0x80 replaces the target.
- Counter saturation: force 70000 stall cycles → stall_cnt_o=16'hFFFF and holds.
- Assert rst_i low while a request is outstanding:
  - All outputs return to reset values immediately.
  - A subsequent ack is ignored.
  - Fetch restarts at RESET_PC only after start_i.
